// File: rtl/axi_wdata_chs.sv
`default_nettype none
// ============================================================================
// Module   : axi_wdata_chs
// Purpose  : AXI write-data channel of the MMU wrapper. W beats from the
//            application side are buffered in a first-word-fall-through FIFO
//            and forwarded to the memory controller. Bursts the MMU denies
//            (drop) are consumed and discarded. Each discarded burst gets a
//            SLVERR B response, and drop_done pulses once that response has
//            been accepted.
// Ports    : clk, reset              - clock / async active-high reset
//            in_w*, in_swvalid       - W beat from application
//            out_swready             - W ready to application
//            out_w*, out_mwvalid     - W beat to memory controller
//            in_mwready              - W ready from memory controller
//            in_awid, in_awlen, drop - drop request (one-cycle pulse)
//            out_bid/bresp/bvalid    - B response for dropped bursts
//            in_bready               - B ready from application
//            drop_done               - one-cycle pulse after B handshake
// Revision : 1.0 - initial release
// ============================================================================
module axi_wdata_chs #(
    parameter int BUF_SZ   = 16,
    parameter int ID_WID   = 8,
    parameter int DATA_WID = 32,
    parameter int USER_WID = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WID-1:0]   in_wdata,
    input  logic [DATA_WID/8-1:0] in_wstrb,
    input  logic [USER_WID-1:0]   in_wuser,
    input  logic                  in_wlast,
    input  logic                  in_swvalid,
    output logic                  out_swready,
    output logic [DATA_WID-1:0]   out_wdata,
    output logic [DATA_WID/8-1:0] out_wstrb,
    output logic [USER_WID-1:0]   out_wuser,
    output logic                  out_wlast,
    output logic                  out_mwvalid,
    input  logic                  in_mwready,
    input  logic [ID_WID-1:0]     in_awid,
    input  logic [7:0]            in_awlen,
    input  logic                  drop,
    output logic [ID_WID-1:0]     out_bid,
    output logic [1:0]            out_bresp,
    output logic                  out_bvalid,
    input  logic                  in_bready,
    output logic                  drop_done
);

    localparam int STRB_WID = DATA_WID / 8;
    localparam int AW       = $clog2(BUF_SZ);
    localparam int EW       = USER_WID + DATA_WID + STRB_WID + 1;
    localparam logic [AW:0]  FULL_CNT = (AW + 1)'(BUF_SZ);
    localparam logic [1:0]   BRESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PASS = 2'd1,
        S_DROP = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t state, state_nxt;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [EW-1:0] mem [BUF_SZ];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          empty, full, push, pop;
    logic [EW-1:0] head;

    // Drop bookkeeping
    logic [ID_WID-1:0] id_q, pend_id;
    logic [7:0]        len_q, pend_len;
    logic [7:0]        beat_cnt;
    logic              drop_pend;
    logic              start_drop;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign pop   = out_mwvalid & in_mwready;
    assign push  = in_swvalid & out_swready & (state == S_PASS);

    // Head is forced to zero when empty so the MC side shows clean zeros
    // out of reset and between bursts instead of stale storage contents.
    assign head        = empty ? '0 : mem[rd_ptr];
    assign out_mwvalid = ~empty;
    assign {out_wuser, out_wdata, out_wstrb, out_wlast} = head;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_wuser, in_wdata, in_wstrb, in_wlast};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State machine: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // State machine: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        out_swready = 1'b0;
        out_bvalid  = 1'b0;
        out_bid     = '0;
        out_bresp   = 2'b00;
        start_drop  = 1'b0;
        case (state)
            S_IDLE: begin
                if (drop || drop_pend) begin
                    start_drop = 1'b1;
                    state_nxt  = S_DROP;
                end else if (in_swvalid) begin
                    state_nxt = S_PASS;
                end
            end
            S_PASS: begin
                // No pop-through: a full FIFO refuses input even if the
                // head is leaving this same cycle.
                out_swready = ~full;
                if (in_swvalid && !full && in_wlast) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DROP: begin
                out_swready = 1'b1;
                // Compare before incrementing so len=255 (256 beats)
                // terminates without the counter wrapping first.
                if (in_swvalid && ((beat_cnt == len_q) || in_wlast)) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                out_bvalid = 1'b1;
                out_bid    = id_q;
                out_bresp  = BRESP_SLVERR;
                if (in_bready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Drop context, pending drop, beat counter, completion pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_q      <= '0;
            len_q     <= '0;
            pend_id   <= '0;
            pend_len  <= '0;
            drop_pend <= 1'b0;
            beat_cnt  <= '0;
            drop_done <= 1'b0;
        end else begin
            drop_done <= (state == S_RESP) && in_bready;

            if (start_drop) begin
                // A held pending drop is older than any pulse arriving now.
                if (drop_pend) begin
                    id_q  <= pend_id;
                    len_q <= pend_len;
                end else begin
                    id_q  <= in_awid;
                    len_q <= in_awlen;
                end
                beat_cnt  <= '0;
                drop_pend <= 1'b0;
            end else if (drop && !drop_pend && (state != S_IDLE)) begin
                drop_pend <= 1'b1;
                pend_id   <= in_awid;
                pend_len  <= in_awlen;
            end

            if ((state == S_DROP) && in_swvalid) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_wdata_chs.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_wdata_chs
// Purpose  : Directed self-checking bench for axi_wdata_chs. Beats expected
//            at the memory-controller side are queued when driven and popped
//            by a monitor when the DUT hands them over.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_wdata_chs;

    localparam int BUF_SZ   = 16;
    localparam int ID_WID   = 8;
    localparam int DATA_WID = 32;
    localparam int USER_WID = 2;
    localparam int EW       = USER_WID + DATA_WID + DATA_WID / 8 + 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [DATA_WID-1:0]   in_wdata;
    logic [DATA_WID/8-1:0] in_wstrb;
    logic [USER_WID-1:0]   in_wuser;
    logic                  in_wlast;
    logic                  in_swvalid;
    logic                  out_swready;
    logic [DATA_WID-1:0]   out_wdata;
    logic [DATA_WID/8-1:0] out_wstrb;
    logic [USER_WID-1:0]   out_wuser;
    logic                  out_wlast;
    logic                  out_mwvalid;
    logic                  in_mwready;
    logic [ID_WID-1:0]     in_awid;
    logic [7:0]            in_awlen;
    logic                  drop;
    logic [ID_WID-1:0]     out_bid;
    logic [1:0]            out_bresp;
    logic                  out_bvalid;
    logic                  in_bready;
    logic                  drop_done;

    always #5 clk = ~clk;

    axi_wdata_chs #(
        .BUF_SZ  (BUF_SZ),
        .ID_WID  (ID_WID),
        .DATA_WID(DATA_WID),
        .USER_WID(USER_WID)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_wdata   (in_wdata),
        .in_wstrb   (in_wstrb),
        .in_wuser   (in_wuser),
        .in_wlast   (in_wlast),
        .in_swvalid (in_swvalid),
        .out_swready(out_swready),
        .out_wdata  (out_wdata),
        .out_wstrb  (out_wstrb),
        .out_wuser  (out_wuser),
        .out_wlast  (out_wlast),
        .out_mwvalid(out_mwvalid),
        .in_mwready (in_mwready),
        .in_awid    (in_awid),
        .in_awlen   (in_awlen),
        .drop       (drop),
        .out_bid    (out_bid),
        .out_bresp  (out_bresp),
        .out_bvalid (out_bvalid),
        .in_bready  (in_bready),
        .drop_done  (drop_done)
    );

    logic [EW-1:0] exp_q[$];
    int  n_cmp  = 0;
    int  n_err  = 0;
    int  dd_cnt = 0;
    bit  b_allowed = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk(input logic [31:0] d, input logic l);
        return {d[1:0], d, d[7:4], l};
    endfunction

    // Memory-controller side scoreboard, B and drop_done monitors
    always @(negedge clk) begin
        if (!reset) begin
            if (out_mwvalid && in_mwready) begin
                if (exp_q.size() == 0) begin
                    chk("mc_beat_unexpected", {63'd0, out_mwvalid}, 64'd0);
                end else begin
                    chk("mc_beat", {25'd0, out_wuser, out_wdata, out_wstrb, out_wlast},
                        {25'd0, exp_q.pop_front()});
                end
            end
            if (out_bvalid && !b_allowed) begin
                chk("bvalid_unexpected", {63'd0, out_bvalid}, 64'd0);
            end
            if (drop_done) begin
                dd_cnt++;
            end
            assert (!(drop && dut.drop_pend)) else begin
                n_err++;
                $error("FAIL drop_overlap: observed drop with pending drop, expected none");
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l, input bit pass, input bit lat);
        int waited = 0;
        in_swvalid = 1'b1;
        in_wdata   = d;
        in_wstrb   = d[7:4];
        in_wuser   = d[1:0];
        in_wlast   = l;
        while (!out_swready && waited < 100) begin
            tick;
            waited++;
        end
        if (!out_swready) begin
            chk("swready_timeout", {63'd0, out_swready}, 64'd1);
        end else begin
            if (pass) exp_q.push_back(mk(d, l));
            tick;
            if (lat) begin
                chk("lat_mwvalid", {63'd0, out_mwvalid}, 64'd1);
                chk("lat_wdata", {32'd0, out_wdata}, {32'd0, d});
            end
        end
    endtask

    task automatic end_burst;
        in_swvalid = 1'b0;
        in_wlast   = 1'b0;
    endtask

    task automatic wait_q_empty(input string tag);
        int w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            tick;
            w++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic pulse_drop(input logic [7:0] id, input logic [7:0] len);
        drop     = 1'b1;
        in_awid  = id;
        in_awlen = len;
        tick;
        drop     = 1'b0;
    endtask

    task automatic check_b(input logic [7:0] id);
        int w = 0;
        int d0;
        while (!out_bvalid && w < 50) begin
            tick;
            w++;
        end
        chk("b_valid", {63'd0, out_bvalid}, 64'd1);
        chk("b_id", {56'd0, out_bid}, {56'd0, id});
        chk("b_resp", {62'd0, out_bresp}, 64'd2);
        tick;
        tick;
        chk("b_valid_hold", {63'd0, out_bvalid}, 64'd1);
        chk("b_id_hold", {56'd0, out_bid}, {56'd0, id});
        d0 = dd_cnt;
        in_bready = 1'b1;
        tick;
        in_bready = 1'b0;
        chk("drop_done_hi", {63'd0, drop_done}, 64'd1);
        chk("b_valid_clear", {63'd0, out_bvalid}, 64'd0);
        tick;
        chk("drop_done_lo", {63'd0, drop_done}, 64'd0);
        chk("drop_done_pulses", 64'(dd_cnt - d0), 64'd1);
        b_allowed = 1'b0;
    endtask

    initial begin
        int d0;
        reset      = 1'b1;
        in_wdata   = '0;
        in_wstrb   = '0;
        in_wuser   = '0;
        in_wlast   = 1'b0;
        in_swvalid = 1'b0;
        in_mwready = 1'b0;
        in_awid    = '0;
        in_awlen   = '0;
        drop       = 1'b0;
        in_bready  = 1'b0;
        tick;
        tick;

        // Reset state
        chk("rst_swready", {63'd0, out_swready}, 64'd0);
        chk("rst_mwvalid", {63'd0, out_mwvalid}, 64'd0);
        chk("rst_wdata",   {32'd0, out_wdata}, 64'd0);
        chk("rst_wlast",   {63'd0, out_wlast}, 64'd0);
        chk("rst_bvalid",  {63'd0, out_bvalid}, 64'd0);
        chk("rst_bid",     {56'd0, out_bid}, 64'd0);
        chk("rst_bresp",   {62'd0, out_bresp}, 64'd0);
        chk("rst_dd",      {63'd0, drop_done}, 64'd0);
        reset = 1'b0;
        tick;

        // Pass burst: 4 beats, one-cycle latency, one-cycle IDLE bubble
        in_mwready = 1'b1;
        in_swvalid = 1'b1;
        in_wdata   = 32'h11;
        #0;
        chk("idle_bubble", {63'd0, out_swready}, 64'd0);
        send_beat(32'h11, 1'b0, 1'b1, 1'b1);
        send_beat(32'h22, 1'b0, 1'b1, 1'b1);
        send_beat(32'h33, 1'b0, 1'b1, 1'b1);
        send_beat(32'h44, 1'b1, 1'b1, 1'b1);
        end_burst;
        chk("idle_after_pass", {63'd0, out_swready}, 64'd0);
        wait_q_empty("pass_drain");

        // Backpressure: 20-beat burst into a 16-deep FIFO
        in_mwready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_beat(32'h100 + 32'(i), 1'b0, 1'b1, 1'b0);
        end
        in_swvalid = 1'b1;
        in_wdata   = 32'h110;
        tick;
        tick;
        chk("full_stall", {63'd0, out_swready}, 64'd0);
        chk("full_mwvalid", {63'd0, out_mwvalid}, 64'd1);
        in_mwready = 1'b1;
        for (int i = 16; i < 20; i++) begin
            send_beat(32'h100 + 32'(i), (i == 19), 1'b1, 1'b0);
        end
        end_burst;
        wait_q_empty("bp_drain");

        // Drop: 4 beats discarded, SLVERR B, drop_done pulse
        b_allowed = 1'b1;
        pulse_drop(8'h5A, 8'd3);
        for (int i = 0; i < 4; i++) begin
            send_beat(32'h200 + 32'(i), (i == 3), 1'b0, 1'b0);
        end
        end_burst;
        chk("drop_no_mc", {63'd0, out_mwvalid}, 64'd0);
        check_b(8'h5A);

        // Drop pulse during an 8-beat pass burst
        b_allowed = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                drop     = 1'b1;
                in_awid  = 8'h07;
                in_awlen = 8'd0;
            end
            send_beat(32'h300 + 32'(i), (i == 7), 1'b1, 1'b0);
            drop = 1'b0;
        end
        end_burst;
        wait_q_empty("pend_pass_drain");
        send_beat(32'h3FF, 1'b1, 1'b0, 1'b0);
        end_burst;
        check_b(8'h07);

        // Early wlast in drop, then a normal pass burst
        b_allowed = 1'b1;
        pulse_drop(8'h33, 8'd7);
        for (int i = 0; i < 3; i++) begin
            send_beat(32'h400 + 32'(i), (i == 2), 1'b0, 1'b0);
        end
        end_burst;
        chk("early_resp", {63'd0, out_bvalid}, 64'd1);
        check_b(8'h33);
        send_beat(32'h501, 1'b0, 1'b1, 1'b0);
        send_beat(32'h502, 1'b1, 1'b1, 1'b0);
        end_burst;
        wait_q_empty("post_early_pass");

        // Reset mid-DROP with beats still buffered for the MC
        in_mwready = 1'b0;
        send_beat(32'h601, 1'b0, 1'b1, 1'b0);
        send_beat(32'h602, 1'b1, 1'b1, 1'b0);
        end_burst;
        tick;
        chk("pre_rst_mwvalid", {63'd0, out_mwvalid}, 64'd1);
        pulse_drop(8'h44, 8'd3);
        send_beat(32'h701, 1'b0, 1'b0, 1'b0);
        send_beat(32'h702, 1'b0, 1'b0, 1'b0);
        end_burst;
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        d0 = dd_cnt;
        chk("mid_rst_swready", {63'd0, out_swready}, 64'd0);
        chk("mid_rst_mwvalid", {63'd0, out_mwvalid}, 64'd0);
        chk("mid_rst_wdata",   {32'd0, out_wdata}, 64'd0);
        chk("mid_rst_bvalid",  {63'd0, out_bvalid}, 64'd0);
        chk("mid_rst_bid",     {56'd0, out_bid}, 64'd0);
        chk("mid_rst_dd",      {63'd0, drop_done}, 64'd0);
        tick;
        reset = 1'b0;
        in_mwready = 1'b1;
        repeat (5) tick;
        chk("post_rst_no_b", {63'd0, out_bvalid}, 64'd0);
        chk("post_rst_no_dd", 64'(dd_cnt - d0), 64'd0);
        chk("post_rst_empty", {63'd0, out_mwvalid}, 64'd0);
        chk("post_rst_idle", {63'd0, out_swready}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
